// File: rtl/debug_tx_sender_pkg.sv
// Shared debugger definitions: transmit FSM encoding, snapshot section layout
// and word/byte sizing helpers.
package debug_tx_sender_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_LATCH   = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Stream layout: PC, cycle count, register file, data memory.
  localparam int HDR_WORDS = 2;
  localparam int REG_BASE  = HDR_WORDS;

  function automatic int mem_base(input int n_regs);
    return HDR_WORDS + n_regs;
  endfunction

  function automatic int bytes_per_word(input int nb_data);
    return nb_data / 8;
  endfunction

endpackage

// File: rtl/debug_tx_sender_word_byte_serializer.sv
// Word-to-byte serializer: parallel load, MSB byte presented first, shifts one
// byte per advance and flags the final byte of the word.
module word_byte_serializer
  import debug_tx_sender_pkg::*;
#(
  parameter int NB_DATA = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [NB_DATA-1:0] load_data,
  input  logic               advance,
  output logic [7:0]         byte_out,
  output logic               last_byte
);

  localparam int BPW   = bytes_per_word(NB_DATA);
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [NB_DATA-1:0] sr_q;
  logic [CNT_W-1:0]   cnt_q;

  assign byte_out  = sr_q[NB_DATA-1 -: 8];
  assign last_byte = (cnt_q == CNT_W'(BPW - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (load) begin
      sr_q  <= load_data;
      cnt_q <= '0;
    end else if (advance) begin
      // Zero fill keeps byte_out at 0 once a word has fully drained.
      sr_q  <= sr_q << 8;
      cnt_q <= last_byte ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/debug_tx_sender.sv
// Debugger transmit engine: snapshots PC/cycle count on start, then streams
// PC, cycle count, register file and data memory to the UART, MSB byte first.
module debug_tx_sender
  import debug_tx_sender_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int N_REGS  = 32,
  parameter int N_MEM   = 32,
  parameter int NB_ADDR = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               is_start_send,
  input  logic [NB_DATA-1:0] i_pc,
  input  logic [NB_DATA-1:0] i_cycle_count,
  output logic [NB_ADDR-1:0] o_reg_addr,
  input  logic [NB_DATA-1:0] i_reg_data,
  output logic [NB_ADDR-1:0] o_mem_addr,
  input  logic [NB_DATA-1:0] i_mem_data,
  output logic [7:0]         o_tx_data,
  output logic               os_tx_start,
  input  logic               is_tx_done,
  output logic               os_busy,
  output logic               os_done_send
);

  localparam int N_WORDS  = HDR_WORDS + N_REGS + N_MEM;
  localparam int MEM_BASE = mem_base(N_REGS);
  localparam int IDX_W    = $clog2(N_WORDS);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [NB_DATA-1:0] pc_q, cyc_q, load_word;
  logic [NB_ADDR-1:0] reg_addr_q, mem_addr_q, reg_addr_w, mem_addr_w;
  logic               in_reg, in_mem, last_word, last_byte;
  logic               accept, ser_load, ser_adv, idx_inc;

  assign in_mem     = (idx_q >= IDX_W'(MEM_BASE));
  assign in_reg     = !in_mem && (idx_q >= IDX_W'(REG_BASE));
  assign reg_addr_w = NB_ADDR'(idx_q - IDX_W'(REG_BASE));
  assign mem_addr_w = NB_ADDR'(idx_q - IDX_W'(MEM_BASE));
  assign last_word  = (idx_q == IDX_W'(N_WORDS - 1));

  // Address is driven combinationally in FETCH so the one-cycle read data
  // lands in LATCH; the registered copy holds it afterwards.
  assign o_reg_addr = (state_q == ST_FETCH && in_reg) ? reg_addr_w : reg_addr_q;
  assign o_mem_addr = (state_q == ST_FETCH && in_mem) ? mem_addr_w : mem_addr_q;

  always_comb begin
    load_word = i_mem_data;
    if (idx_q == IDX_W'(0))      load_word = pc_q;
    else if (idx_q == IDX_W'(1)) load_word = cyc_q;
    else if (in_reg)             load_word = i_reg_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    ser_load     = 1'b0;
    ser_adv      = 1'b0;
    idx_inc      = 1'b0;
    os_tx_start  = 1'b0;
    os_done_send = 1'b0;
    os_busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        os_busy = 1'b0;
        if (is_start_send) begin
          accept  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        ser_load = 1'b1;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        os_tx_start = 1'b1;
        state_d     = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (is_tx_done) begin
          ser_adv = 1'b1;
          if (!last_byte) begin
            state_d = ST_SEND;
          end else if (last_word) begin
            state_d = ST_DONE;
          end else begin
            idx_inc = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        os_busy      = 1'b0;
        os_done_send = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q      <= '0;
      pc_q       <= '0;
      cyc_q      <= '0;
      reg_addr_q <= '0;
      mem_addr_q <= '0;
    end else begin
      if (accept) begin
        idx_q <= '0;
        pc_q  <= i_pc;
        cyc_q <= i_cycle_count;
      end else if (idx_inc) begin
        idx_q <= idx_q + IDX_W'(1);
      end
      if (state_q == ST_FETCH && in_reg) reg_addr_q <= reg_addr_w;
      if (state_q == ST_FETCH && in_mem) mem_addr_q <= mem_addr_w;
    end
  end

  word_byte_serializer #(.NB_DATA(NB_DATA)) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .load_data (load_word),
    .advance   (ser_adv),
    .byte_out  (o_tx_data),
    .last_byte (last_byte)
  );

endmodule

// File: tb/tb_debug_tx_sender.sv
// Bench for debug_tx_sender: UART and register/memory models, expected byte
// stream built directly from the snapshot contents.
module tb_debug_tx_sender;

  localparam int NB_DATA = 32;
  localparam int N_REGS  = 32;
  localparam int N_MEM   = 32;
  localparam int NB_ADDR = 5;
  localparam int N_BYTES = 4 * (2 + N_REGS + N_MEM);
  localparam int BUDGET  = 6000;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               is_start_send = 1'b0;
  logic               is_tx_done = 1'b0;
  logic [NB_DATA-1:0] i_pc = '0, i_cycle_count = '0, i_reg_data = '0, i_mem_data = '0;
  logic [NB_ADDR-1:0] o_reg_addr, o_mem_addr;
  logic [7:0]         o_tx_data;
  logic               os_tx_start, os_busy, os_done_send;

  always #5 clk = ~clk;

  debug_tx_sender #(.NB_DATA(NB_DATA), .N_REGS(N_REGS), .N_MEM(N_MEM), .NB_ADDR(NB_ADDR)) dut (
    .clk(clk), .rst(rst), .is_start_send(is_start_send), .i_pc(i_pc),
    .i_cycle_count(i_cycle_count), .o_reg_addr(o_reg_addr), .i_reg_data(i_reg_data),
    .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data), .o_tx_data(o_tx_data),
    .os_tx_start(os_tx_start), .is_tx_done(is_tx_done), .os_busy(os_busy),
    .os_done_send(os_done_send)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] cyc;
    int          pattern;     // 0: reg[i]=i, mem[i]=A0000000+i; 1: random
    int          delay;       // UART cycles from start to done
    bit          spurious;    // extra done pulses outside WAIT_TX
    int          restart_at;  // byte index at which a second start is pulsed, -1 none
    bit          pc_change;   // i_pc forced to all-ones right after start
    int          exp_bytes;
    int          exp_done;
  } vec_t;

  logic [31:0] regs [N_REGS];
  logic [31:0] mems [N_MEM];
  logic [7:0]  cap [$];
  logic [7:0]  exp_q [$];
  int          done_cnt = 0, total_done = 0, cyc = 0, last_txd_cyc = 0, done_cyc = 0;
  int          tx_delay = 5, pend = 0;
  bit          spurious = 1'b0;
  int          n_chk = 0, n_pass = 0;
  vec_t        vecs [6];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Register/memory read ports (data one cycle after address) and UART model.
  initial begin
    logic [NB_ADDR-1:0] ra, ma;
    ra = '0;
    ma = '0;
    forever begin
      @(negedge clk);
      cyc++;
      i_reg_data = regs[ra];
      i_mem_data = mems[ma];
      ra = o_reg_addr;
      ma = o_mem_addr;
      is_tx_done = 1'b0;
      if (!rst) begin
        pend = 0;
      end else begin
        if (os_done_send) begin
          done_cnt++;
          total_done++;
          done_cyc = cyc;
        end
        if (os_tx_start) begin
          cap.push_back(o_tx_data);
          pend = tx_delay;
          if (spurious) is_tx_done = 1'b1;
        end else if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            is_tx_done   = 1'b1;
            last_txd_cyc = cyc;
          end
        end else if (spurious && cyc == last_txd_cyc + 1) begin
          is_tx_done = 1'b1;
        end
      end
    end
  end

  task automatic fill(input int pattern);
    for (int i = 0; i < N_REGS; i++) regs[i] = (pattern == 0) ? 32'(i) : $urandom;
    for (int i = 0; i < N_MEM; i++)  mems[i] = (pattern == 0) ? 32'hA000_0000 + 32'(i) : $urandom;
  endtask

  task automatic build_exp(input logic [31:0] pc, input logic [31:0] cy);
    logic [31:0] words [$];
    exp_q.delete();
    words.push_back(pc);
    words.push_back(cy);
    for (int i = 0; i < N_REGS; i++) words.push_back(regs[i]);
    for (int i = 0; i < N_MEM; i++)  words.push_back(mems[i]);
    foreach (words[w])
      for (int b = 3; b >= 0; b--) exp_q.push_back(words[w][b*8 +: 8]);
  endtask

  task automatic run_dump(input vec_t v, input string tag);
    int n, mism;
    bit did;
    i_pc = v.pc;
    i_cycle_count = v.cyc;
    fill(v.pattern);
    build_exp(v.pc, v.cyc);
    tx_delay = v.delay;
    spurious = v.spurious;
    cap.delete();
    done_cnt = 0;
    @(negedge clk) is_start_send = 1'b1;
    @(negedge clk) is_start_send = 1'b0;
    if (v.pc_change) i_pc = 32'hFFFF_FFFF;
    chk({tag, " busy_after_start"}, 64'(os_busy), 64'd1);
    chk({tag, " no_tx_in_fetch"}, 64'(os_tx_start), 64'd0);
    @(negedge clk);
    chk({tag, " no_tx_in_latch"}, 64'(os_tx_start), 64'd0);
    @(negedge clk);
    chk({tag, " first_tx_start"}, 64'(os_tx_start), 64'd1);
    chk({tag, " first_tx_byte"}, 64'(o_tx_data), 64'(exp_q[0]));
    n = 0;
    did = 1'b0;
    while (done_cnt == 0 && n < BUDGET) begin
      @(negedge clk);
      n++;
      if (v.restart_at >= 0 && !did && cap.size() == v.restart_at) begin
        is_start_send = 1'b1;
        did = 1'b1;
      end else begin
        is_start_send = 1'b0;
      end
    end
    is_start_send = 1'b0;
    chk({tag, " done_within_budget"}, 64'(n < BUDGET), 64'd1);
    repeat (3) @(negedge clk);
    chk({tag, " done_count"}, 64'(done_cnt), 64'(v.exp_done));
    chk({tag, " done_latency"}, 64'(done_cyc), 64'(last_txd_cyc + 1));
    chk({tag, " byte_count"}, 64'(cap.size()), 64'(v.exp_bytes));
    mism = 0;
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
      if (cap[i] !== exp_q[i]) mism++;
    chk({tag, " stream_mismatches"}, 64'(mism), 64'd0);
    if (cap.size() >= 4)
      chk({tag, " first_word_pc"}, 64'({cap[0], cap[1], cap[2], cap[3]}), 64'(v.pc));
    chk({tag, " busy_low_after"}, 64'(os_busy), 64'd0);
  endtask

  initial begin
    int n, base_done;
    vecs[0] = '{32'h40, 32'h7, 0, 5, 1'b0, -1, 1'b0, N_BYTES, 1};
    vecs[1] = '{32'h40, 32'h7, 0, 5, 1'b1, 10, 1'b0, N_BYTES, 1};
    vecs[2] = '{32'h40, 32'h7, 0, 5, 1'b0, -1, 1'b1, N_BYTES, 1};
    for (int i = 3; i < 6; i++)
      vecs[i] = '{$urandom, $urandom, 1, int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)),
                  -1, 1'b0, N_BYTES, 1};
    fill(0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({o_tx_data, os_tx_start, os_busy, os_done_send, o_reg_addr, o_mem_addr}), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_outputs", 64'({o_tx_data, os_tx_start, os_busy, os_done_send}), 64'd0);

    // Basic, ignored inputs, input change, random vectors
    for (int i = 0; i < 6; i++) run_dump(vecs[i], $sformatf("vec%0d", i));

    // Reset abort after byte 50, then a full dump from the PC again
    fill(0);
    tx_delay = 5;
    spurious = 1'b0;
    i_pc = 32'h40;
    i_cycle_count = 32'h7;
    cap.delete();
    done_cnt = 0;
    @(negedge clk) is_start_send = 1'b1;
    @(negedge clk) is_start_send = 1'b0;
    n = 0;
    while (cap.size() < 51 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_byte50", 64'(n < BUDGET), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_outputs_c1", 64'({o_tx_data, os_tx_start, os_busy, os_done_send, o_reg_addr, o_mem_addr}), 64'd0);
    @(negedge clk);
    chk("abort_outputs_c2", 64'({o_tx_data, os_tx_start, os_busy, os_done_send, o_reg_addr, o_mem_addr}), 64'd0);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("abort_stays_idle", 64'({os_busy, os_tx_start}), 64'd0);
    run_dump(vecs[0], "after_abort");

    // Back-to-back dumps as the step controller would issue them
    base_done = total_done;
    for (int i = 0; i < 3; i++) begin
      vecs[3].pc = $urandom;
      run_dump(vecs[3], $sformatf("b2b%0d", i));
    end
    chk("b2b_done_pulses", 64'(total_done - base_done), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
